// File: rtl/leb128_encoder.sv
// rtl/leb128_encoder.sv - signed/unsigned LEB128 byte-stream encoder
// Optional out_count port is enabled by defining LEB128_COUNT_EN.
module leb128_encoder #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_signed,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
`ifdef LEB128_COUNT_EN
  ,
  output logic [3:0]       out_count
`endif
);

  localparam int MAX_BYTES = (WIDTH + 6) / 7;
  localparam logic [3:0] CNT_LAST = 4'(MAX_BYTES - 1);

  typedef enum logic {
    S_IDLE,
    S_EMIT
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic             r_signed;
  logic [3:0]       r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_lsh;
  logic [WIDTH-1:0] w_ash;
  logic [WIDTH-1:0] w_shift;
  logic             w_last_val;
  logic             w_last;

  assign w_lsh   = r_sreg >> 7;
  assign w_ash   = WIDTH'($signed(r_sreg) >>> 7);
  assign w_shift = r_signed ? w_ash : w_lsh;

  // Signed encodings stop once the remaining bits are pure sign extension of bit 6.
  assign w_last_val = r_signed ? ((w_ash == '0 && !r_sreg[6]) || (w_ash == '1 && r_sreg[6]))
                               : (w_lsh == '0);
  assign w_last     = w_last_val || (r_cnt == CNT_LAST);

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_valid & w_last;
  assign out_data  = r_out_valid ? {~w_last, r_sreg[6:0]} : 8'h00;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_sreg      <= '0;
      r_signed    <= 1'b0;
      r_cnt       <= 4'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sreg      <= in_data;
            r_signed    <= in_signed;
            r_cnt       <= 4'd0;
            r_state     <= S_EMIT;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            if (w_last) begin
              r_state     <= S_IDLE;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
            end else begin
              r_sreg <= w_shift;
              r_cnt  <= r_cnt + 4'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LEB128_COUNT_EN
  logic [3:0] r_count;

  assign out_count = r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= 4'd0;
    end else if (r_out_valid && out_ready && w_last) begin
      r_count <= r_cnt + 4'd1;
    end
  end
`endif

endmodule

// File: doc/leb128_encoder.md
LEB128_ENCODER -- requirements
Module: leb128_encoder

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning the bit width of the input integer (legal values 8..64).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port in_data, input, WIDTH bits: integer to encode.
REQ-005 SHALL have port in_signed, input, 1 bit: 1 selects signed LEB128 and 0 selects unsigned.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data and in_signed are valid.
REQ-007 SHALL have port in_ready, output, 1 bit: encoder can accept a new integer.
REQ-008 SHALL have port out_data, output, 8 bits: encoded byte.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes the byte.
REQ-011 SHALL have port out_last, output, 1 bit: the current byte is the final byte of the encoding.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and EMIT.
REQ-013 In IDLE, SHALL assert in_ready=1 and out_valid=0.
REQ-014 In EMIT, SHALL assert in_ready=0 and out_valid=1.
REQ-015 On in_valid&&in_ready, SHALL:
- capture in_data into a WIDTH-bit shift register;
- capture in_signed;
- clear the byte counter;
- move to EMIT.
REQ-016 SHALL present the first byte in the cycle after acceptance (latency 1).
REQ-017 SHALL form out_data[6:0] from shift register bits [6:0].
REQ-018 SHALL set out_data[7] = ~out_last.
REQ-019 Unsigned mode: SHALL assert out_last when (reg >> 7) == 0, using a logical shift.
REQ-020 Signed mode: SHALL assert out_last when either:
- (reg >>> 7) == 0 and reg[6] == 0; or
- (reg >>> 7) == all-ones and reg[6] == 1.
The shift is arithmetic, sign-extending from bit WIDTH-1 of the captured value.
REQ-021 On out_valid&&out_ready with out_last=0, SHALL shift the register right by 7 (arithmetic if signed, logical if unsigned) and increment the byte counter.
REQ-022 On out_valid&&out_ready with out_last=1, SHALL return to IDLE, with in_ready=1 on the next cycle.
REQ-023 While out_valid=1 and out_ready=0, SHALL hold out_data, out_last and all internal state stable.
REQ-024 SHALL emit at most ceil(WIDTH/7) bytes, i.e. 10 for WIDTH=64.
REQ-025 SHALL force out_last=1 when the byte counter reaches ceil(WIDTH/7)-1, regardless of the register contents.
REQ-026 SHALL ignore in_valid while in EMIT; no input is captured or lost-acknowledged.
REQ-027 SHALL sustain a throughput of one byte per cycle while out_ready=1.

Reset
REQ-028 SHALL, when reset=0 at a clock edge, force:
- the FSM to IDLE;
- in_ready=1;
- out_valid=0, out_last=0, out_data=0;
- the byte counter and shift register to 0.
REQ-029 Reset during EMIT SHALL abandon the encoding; no further bytes of it appear after reset release.
REQ-030 The first acceptance SHALL be possible in the first cycle with reset=1.

Configuration
REQ-031 With macro LEB128_COUNT_EN defined, SHALL add output port out_count (4 bits):
- equals the total byte count of the most recently completed encoding;
- updates on the cycle the last byte handshakes;
- reset value 0.
REQ-032 Without LEB128_COUNT_EN, out_count and its register SHALL be absent.
REQ-033 Without LEB128_COUNT_EN, all other behaviour SHALL be unchanged.

Verification
REQ-034 SHALL cover: signed 42 -> single byte 0x2A, out_last=1; with count enabled, out_count=1.
REQ-035 SHALL cover the signed edge values:
- signed -1 -> 0x7F;
- signed 64 -> 0xC0, 0x00;
- signed -123456 -> 0xC0, 0xBB, 0x78.
REQ-036 SHALL cover the unsigned values:
- unsigned 624485 -> 0xE5, 0x8E, 0x26;
- unsigned 2^64-1 -> nine 0xFF then 0x01, with 10 bytes and out_last only on the 10th.
REQ-037 SHALL cover signed -2^63 -> nine 0x80 then 0x7F.
REQ-038 SHALL cover backpressure: unsigned 624485 with out_ready toggled 0/1 every cycle -> the same three bytes, each held stable while stalled, and in_ready=0 throughout EMIT.
REQ-039 SHALL cover reset mid-encode: reset=0 after the first byte of unsigned 624485 -> out_valid=0 the next cycle, then a new input 42 encodes as 0x2A only.
